video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the simulated-CRT / VGA path. Produces horizontal and vertical sync, a display-enable window, and the current beam position for any mode described by front-porch / sync / back-porch parameters. Sync polarity is configurable, and a pixel clock-enable allows pixel rates below `clk`. It sits at the top of every video design and drives the pixel generators and the `hsync`/`vsync` pins directly.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, active level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, active level of `vsync`
- `POS_W`, 10, width of `hpos`/`vpos`; must satisfy 2^POS_W ≥ max(H_TOTAL, V_TOTAL)

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `pix_ce`  input  1  pixel clock-enable; the raster advances only on cycles where it is 1
- `hsync`  output  1  horizontal sync at `HSYNC_POL` level
- `vsync`  output  1  vertical sync at `VSYNC_POL` level
- `display_on`  output  1  1 when the presented position is visible
- `hpos`  output  POS_W  presented horizontal position
- `vpos`  output  POS_W  presented vertical position
- `line_start`  output  1  1 while `hpos` == 0
- `frame_start`  output  1  1 while `hpos` == 0 and `vpos` == 0

## Operation
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL = the same sum over the V parameters. Every parameter must be ≥ 1.
- Regions per line: visible [0, H_DISPLAY-1], front porch, sync [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], back porch. The vertical regions follow the same scheme.
- State machine:
  - IDLE is entered by reset. It holds until the first `pix_ce`, which presents (0,0) and moves to RUN.
  - RUN: each `pix_ce` advances `hpos`. At `hpos` == H_TOTAL-1, `hpos` wraps to 0 and `vpos` advances. At `vpos` == V_TOTAL-1 together with `hpos` wrap, `vpos` wraps to 0.
- All outputs are registered and mutually aligned. `hsync`, `vsync`, `display_on`, `line_start` and `frame_start` always decode the `hpos`/`vpos` currently presented, with no skew. The decode uses next-state values.
- Without `pix_ce`, all outputs hold.

## Timing
- Reset values (IDLE): `hpos`=0, `vpos`=0, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL, `display_on`=0, `line_start`=0, `frame_start`=0.
- First `pix_ce` after reset deasserts: on the next edge `hpos`=0, `vpos`=0, `display_on`=1, `line_start`=1, `frame_start`=1.
- Pulse width: `line_start` and `frame_start` each last one pixel period, which spans multiple `clk` cycles when `pix_ce` is divided.
- Sync spans: `hsync` is active for exactly H_SYNC pixels per line. `vsync` is active for exactly V_SYNC full lines, with edges coincident with `hpos` == 0.
- Reset mid-frame: all outputs go to their reset values asynchronously. The raster restarts at (0,0) on the first `pix_ce` after release.
- `pix_ce` tied to 1: one pixel per `clk`; frame period = H_TOTAL×V_TOTAL cycles.

## Configuration
- `VTG_FRAME_COUNT_EN`:
  - Defined: adds output `frame_cnt` (16 bits). It resets to 0, increments by 1 at every `vpos` wrap to 0 (not on the first frame after reset), wraps 0xFFFF→0, and is aligned with `frame_start`.
  - Undefined: the port and counter do not exist.

## Structure
- Shared package `video_timing_pkg` holds the standard mode constant sets (640×480@60, 800×600@60, 320×240 test mode) and the sync-polarity constants. Instantiations pick a mode from there.
- One sub-module, `vtg_axis_counter`, instantiated twice (horizontal, vertical):
  - Parameters: DISPLAY, FRONT, SYNC, BACK, POL.
  - Inputs: `advance`.
  - Outputs: position, `wrap`, `sync`, `visible`.
  - The vertical instance's `advance` = horizontal `wrap` & `pix_ce`.

## Test plan
- 640×480 defaults, `pix_ce`=1, one full frame: `hsync` low for `hpos` 656..751, `vsync` low for `vpos` 490..491, frame period 420000 cycles, `display_on` count 307200.
- Release reset, then `pix_ce` first at cycle 5: outputs hold reset values until then; the next edge shows (0,0) with `frame_start`=1 and `display_on`=1.
- `pix_ce` every 4th cycle: each position held 4 clks, `line_start` high 4 clks, line period 3200 clks.
- Assert reset at `hpos`=700, `vpos`=300: outputs reach reset values immediately without a clock; the restart is at (0,0).
- HSYNC_POL=VSYNC_POL=1 with tiny mode (4,1,1,1 / 2,1,1,1): `hsync` high only at `hpos`=5, `vsync` high only on `vpos`=3, `hpos` wraps 6→0.
- `VTG_FRAME_COUNT_EN` defined, tiny mode: `frame_cnt` = 0,1,2,3 across four frames, incrementing in the same cycle `frame_start` rises.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: standard mode constants, sync polarity levels
// and the raster state encoding used by video_timing_gen and its axis counters.
package video_timing_pkg;

  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } axis_mode_t;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam axis_mode_t MODE_640X480_H = '{display: 640, front: 16, sync: 96,  back: 48};
  localparam axis_mode_t MODE_640X480_V = '{display: 480, front: 10, sync: 2,   back: 33};
  localparam logic       MODE_640X480_POL = SYNC_ACTIVE_LOW;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam axis_mode_t MODE_800X600_H = '{display: 800, front: 40, sync: 128, back: 88};
  localparam axis_mode_t MODE_800X600_V = '{display: 600, front: 1,  sync: 4,   back: 23};
  localparam logic       MODE_800X600_POL = SYNC_ACTIVE_HIGH;

  // 320x240 reduced test mode for fast simulation
  localparam axis_mode_t MODE_320X240_H = '{display: 320, front: 8,  sync: 32,  back: 40};
  localparam axis_mode_t MODE_320X240_V = '{display: 240, front: 3,  sync: 4,   back: 15};
  localparam logic       MODE_320X240_POL = SYNC_ACTIVE_LOW;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } vtg_state_t;

  function automatic int axis_total(input axis_mode_t m);
    return m.display + m.front + m.sync + m.back;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis (horizontal or vertical): position counter with wrap, a
// registered sync output and the visible decode of the position being loaded.
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int   DISPLAY = 640,
  parameter int   FRONT   = 16,
  parameter int   SYNC    = 96,
  parameter int   BACK    = 48,
  parameter logic POL     = SYNC_ACTIVE_LOW,
  parameter int   POS_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             sync,
  output logic             visible
);

  localparam int TOTAL      = DISPLAY + FRONT + SYNC + BACK;
  localparam int SYNC_START = DISPLAY + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [POS_W-1:0] pos_next;
  logic             sync_next;

  assign wrap = (pos == POS_W'(TOTAL - 1));

  always_comb begin
    pos_next = pos;
    if (load) begin
      pos_next = '0;
    end else if (advance) begin
      pos_next = wrap ? '0 : pos + POS_W'(1);
    end
  end

  // Decodes look at the position about to be registered so sync lines up with pos.
  assign sync_next = (pos_next >= POS_W'(SYNC_START)) && (pos_next < POS_W'(SYNC_END));
  assign visible   = (pos_next < POS_W'(DISPLAY));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos  <= '0;
      sync <= ~POL;
    end else if (load || advance) begin
      pos  <= pos_next;
      sync <= sync_next ? POL : ~POL;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, display enable and beam position from porch/sync
// parameters. Define VTG_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_DISPLAY = MODE_640X480_H.display,
  parameter int   H_FRONT   = MODE_640X480_H.front,
  parameter int   H_SYNC    = MODE_640X480_H.sync,
  parameter int   H_BACK    = MODE_640X480_H.back,
  parameter int   V_DISPLAY = MODE_640X480_V.display,
  parameter int   V_FRONT   = MODE_640X480_V.front,
  parameter int   V_SYNC    = MODE_640X480_V.sync,
  parameter int   V_BACK    = MODE_640X480_V.back,
  parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   POS_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
`ifdef VTG_FRAME_COUNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             line_start,
  output logic             frame_start
);

  vtg_state_t state;
  logic       load;
  logic       h_advance;
  logic       v_advance;
  logic       h_wrap;
  logic       v_wrap;
  logic       h_visible;
  logic       v_visible;
  logic       frame_wrap;

  // The first pix_ce out of IDLE presents (0,0) instead of stepping past it.
  assign load       = pix_ce && (state == ST_IDLE);
  assign h_advance  = pix_ce && (state == ST_RUN);
  assign v_advance  = h_advance && h_wrap;
  assign frame_wrap = v_advance && v_wrap;

  vtg_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .POS_W   (POS_W)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (h_advance),
    .pos     (hpos),
    .wrap    (h_wrap),
    .sync    (hsync),
    .visible (h_visible)
  );

  vtg_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .POS_W   (POS_W)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (v_advance),
    .pos     (vpos),
    .wrap    (v_wrap),
    .sync    (vsync),
    .visible (v_visible)
  );

  // NOTE: with no pix_ce the flops simply keep their value; holding in a clocked
  // block is an enable, not a latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VTG_FRAME_COUNT_EN
      frame_cnt   <= '0;
`endif
    end else if (pix_ce) begin
      state       <= ST_RUN;
      display_on  <= h_visible && v_visible;
      line_start  <= load || h_wrap;
      frame_start <= load || frame_wrap;
`ifdef VTG_FRAME_COUNT_EN
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: three raster configurations driven by shared random
// pix_ce/reset and compared every cycle against a pixel-count reference model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Default 640x480 instance
  logic       def_hs, def_vs, def_de, def_ls, def_fs;
  logic [9:0] def_hpos, def_vpos;
  logic [15:0] def_fc;
  // Small custom mode: H 16/3/4/5 (28), V 10/2/3/2 (17)
  logic       sml_hs, sml_vs, sml_de, sml_ls, sml_fs;
  logic [4:0] sml_hpos, sml_vpos;
  logic [15:0] sml_fc;
  // Tiny positive-sync mode: H 4/1/1/1 (7), V 2/1/1/1 (5)
  logic       tny_hs, tny_vs, tny_de, tny_ls, tny_fs;
  logic [2:0] tny_hpos, tny_vpos;
  logic [15:0] tny_fc;

  video_timing_gen u_def (
    .clk (clk), .reset (reset), .pix_ce (pix_ce),
    .hsync (def_hs), .vsync (def_vs), .display_on (def_de),
    .hpos (def_hpos), .vpos (def_vpos),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt (def_fc),
`endif
    .line_start (def_ls), .frame_start (def_fs)
  );

  video_timing_gen #(
    .H_DISPLAY (16), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
    .V_DISPLAY (10), .V_FRONT (2), .V_SYNC (3), .V_BACK (2),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .POS_W (5)
  ) u_sml (
    .clk (clk), .reset (reset), .pix_ce (pix_ce),
    .hsync (sml_hs), .vsync (sml_vs), .display_on (sml_de),
    .hpos (sml_hpos), .vpos (sml_vpos),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt (sml_fc),
`endif
    .line_start (sml_ls), .frame_start (sml_fs)
  );

  video_timing_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_DISPLAY (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .POS_W (3)
  ) u_tny (
    .clk (clk), .reset (reset), .pix_ce (pix_ce),
    .hsync (tny_hs), .vsync (tny_vs), .display_on (tny_de),
    .hpos (tny_hpos), .vpos (tny_vpos),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt (tny_fc),
`endif
    .line_start (tny_ls), .frame_start (tny_fs)
  );

`ifndef VTG_FRAME_COUNT_EN
  assign def_fc = '0;
  assign sml_fc = '0;
  assign tny_fc = '0;
`endif

  // Reference model: number of pixels presented since the raster started.
  bit started;
  int pix_n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      started <= 1'b0;
      pix_n   <= 0;
    end else if (pix_ce) begin
      if (started) pix_n <= pix_n + 1;
      started <= 1'b1;
    end
  end

  typedef struct {
    int hpos, vpos, hsync, vsync, de, ls, fs, frame;
  } exp_t;

  function automatic exp_t raster(input int hd, hf, hs, hb, vd, vf, vs, vb, hp, vp);
    exp_t e;
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    int line;
    e = '{default: 0};
    e.hsync = (hp == 0);
    e.vsync = (vp == 0);
    if (!started) return e;
    e.hpos  = pix_n % ht;
    line    = pix_n / ht;
    e.vpos  = line % vt;
    e.frame = (line / vt) % 65536;
    e.hsync = (e.hpos >= hd + hf && e.hpos < hd + hf + hs) ? hp : (hp == 0);
    e.vsync = (e.vpos >= vd + vf && e.vpos < vd + vf + vs) ? vp : (vp == 0);
    e.de    = (e.hpos < hd) && (e.vpos < vd);
    e.ls    = (e.hpos == 0);
    e.fs    = (e.hpos == 0) && (e.vpos == 0);
    return e;
  endfunction

  task automatic check_raster(input string name, input exp_t e,
                              input logic [31:0] hp, vp, hs, vs, de, ls, fs, fc);
    check({name, ".hpos"}, hp, e.hpos);
    check({name, ".vpos"}, vp, e.vpos);
    check({name, ".hsync"}, hs, e.hsync);
    check({name, ".vsync"}, vs, e.vsync);
    check({name, ".display_on"}, de, e.de);
    check({name, ".line_start"}, ls, e.ls);
    check({name, ".frame_start"}, fs, e.fs);
`ifdef VTG_FRAME_COUNT_EN
    check({name, ".frame_cnt"}, fc, e.frame);
`endif
  endtask

  task automatic check_all();
    check_raster("def", raster(640, 16, 96, 48, 480, 10, 2, 33, 0, 0),
                 def_hpos, def_vpos, def_hs, def_vs, def_de, def_ls, def_fs, def_fc);
    check_raster("sml", raster(16, 3, 4, 5, 10, 2, 3, 2, 0, 0),
                 sml_hpos, sml_vpos, sml_hs, sml_vs, sml_de, sml_ls, sml_fs, sml_fc);
    check_raster("tny", raster(4, 1, 1, 1, 2, 1, 1, 1, 1, 1),
                 tny_hpos, tny_vpos, tny_hs, tny_vs, tny_de, tny_ls, tny_fs, tny_fc);
  endtask

  // Interval trackers for line_start (default) and frame_start (tiny).
  int cyc;
  int ls_rise, ls_period, ls_width, ls_run;
  int fs_rise, fs_period, de_acc, de_frame;
  bit prev_ls, prev_fs;

  task automatic tracker_clear();
    ls_rise = -1; ls_period = -1; ls_width = -1; ls_run = 0;
    fs_rise = -1; fs_period = -1; de_acc = 0; de_frame = -1;
    prev_ls = 1'b0; prev_fs = 1'b0;
  endtask

  task automatic track();
    if (def_ls && !prev_ls) begin
      if (ls_rise >= 0) ls_period = cyc - ls_rise;
      ls_rise = cyc;
      ls_run  = 0;
    end
    if (def_ls) ls_run++;
    if (!def_ls && prev_ls) ls_width = ls_run;
    if (tny_fs && !prev_fs) begin
      if (fs_rise >= 0) begin
        fs_period = cyc - fs_rise;
        de_frame  = de_acc;
      end
      fs_rise = cyc;
      de_acc  = 0;
    end
    if (tny_de) de_acc++;
    prev_ls = def_ls;
    prev_fs = tny_fs;
  endtask

  task automatic step(input logic ce);
    pix_ce = ce;
    @(negedge clk);
    cyc++;
    check_all();
    track();
  endtask

  initial begin
    int guard;
    cyc    = 0;
    reset  = 1'b0;
    pix_ce = 1'b0;
    tracker_clear();

    // Reset values, then outputs hold until the first pix_ce at cycle 5.
    repeat (3) step(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0);
    check("idle.hsync_inactive", def_hs, 1);
    check("idle.tny_hsync_inactive", tny_hs, 0);
    step(1'b1);
    check("first.hpos", def_hpos, 0);
    check("first.vpos", def_vpos, 0);
    check("first.display_on", def_de, 1);
    check("first.line_start", def_ls, 1);
    check("first.frame_start", def_fs, 1);

    // pix_ce tied high: one pixel per clk.
    tracker_clear();
    repeat (2000) step(1'b1);
    check("ce1.def_line_period", ls_period, 800);
    check("ce1.def_line_start_width", ls_width, 1);
    check("ce1.tny_frame_period", fs_period, 35);
    check("ce1.tny_display_per_frame", de_frame, 8);

    // pix_ce every 4th cycle.
    tracker_clear();
    for (int i = 0; i < 8000; i++) step(i % 4 == 0);
    check("ce4.def_line_period", ls_period, 3200);
    check("ce4.def_line_start_width", ls_width, 4);
    check("ce4.tny_frame_period", fs_period, 140);

    // Random pixel enable.
    repeat (20000) step($urandom_range(0, 3) != 0);

    // Asynchronous reset in the middle of a line, inside the hsync pulse.
    guard = 0;
    while (def_hpos != 10'd700 && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    check("midreset.reach_hpos_700", def_hpos, 700);
    check("midreset.hsync_active", def_hs, 0);
    pix_ce = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset.hpos", def_hpos, 0);
    check("midreset.vpos", def_vpos, 0);
    check("midreset.hsync", def_hs, 1);
    check("midreset.vsync", def_vs, 1);
    check("midreset.line_start", def_ls, 0);
    check("midreset.frame_start", def_fs, 0);
    check("midreset.tny_hsync", tny_hs, 0);
    @(negedge clk);
    check_all();
    step(1'b1);
    reset = 1'b1;
    repeat (2) step(1'b0);
    step(1'b1);
    check("restart.hpos", def_hpos, 0);
    check("restart.vpos", def_vpos, 0);
    check("restart.frame_start", def_fs, 1);
    check("restart.display_on", def_de, 1);
    repeat (3000) step($urandom_range(0, 1) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
